// File: rtl/ws2812b_pkg.sv
// Shared definitions for the WS2812B link: receiver FSM states, default
// bit timings (also used by the transmitter) and the pixel word width.
package ws2812b_pkg;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_IDLE = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } rx_state_t;

  // Nominal bit timings in cycles at 100 MHz
  localparam int T0H = 40;
  localparam int T0L = 85;
  localparam int T1H = 80;
  localparam int T1L = 45;

  // Low time that ends a frame (50 us at 100 MHz)
  localparam int RESET_CYCLES_DEFAULT = 5000;

  localparam int PIXEL_W = 24;

endpackage

// File: rtl/ws2812b_din_sync.sv
// DIN synchronizer (SYNC_STAGES flops, minimum 2) followed by one edge
// register. The level and rise/fall events are all registered so they line
// up in the same cycle: SYNC_STAGES+1 cycles after the pin transition.
module ws2812b_din_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic din_lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_p0;

  // Metastability chain; the MSB is the first usable synchronized sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din};
    end
  end

  // Edge register: delayed level plus rise/fall events aligned with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_lvl <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      din_lvl <= sync_p0[SYNC_STAGES-1];
      rise    <= sync_p0[SYNC_STAGES-1] & ~din_lvl;
      fall    <= ~sync_p0[SYNC_STAGES-1] & din_lvl;
    end
  end

endmodule

// File: rtl/ws2812b_rx.sv
// WS2812B NRZ receiver: measures DIN high pulses, decodes 24-bit pixels
// MSB-first, and ends a frame on a long low gap.
// Optional feature: define WS2812B_RX_FORWARD_EN to forward the stream after
// the first pixel of each frame on DOUT (cascadable pixel node behaviour);
// otherwise DOUT is tied low.
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int THRESH_CYCLES   = 60,
  parameter int MIN_HIGH_CYCLES = 15,
  parameter int MAX_HIGH_CYCLES = 120,
  parameter int RESET_CYCLES    = RESET_CYCLES_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                DIN,
  output logic [PIXEL_W-1:0]  pixel_data,
  output logic                pixel_valid,
  output logic [15:0]         pixel_index,
  output logic                frame_done,
  output logic [15:0]         frame_pixels,
  output logic                bit_error,
  output logic                DOUT
);

  localparam int HCNT_W = $clog2(MAX_HIGH_CYCLES + 1);
  localparam int LCNT_W = $clog2(RESET_CYCLES + 1);
  localparam int BCNT_W = $clog2(PIXEL_W);

  localparam logic [HCNT_W-1:0] H_THR  = HCNT_W'(THRESH_CYCLES);
  localparam logic [HCNT_W-1:0] H_MIN  = HCNT_W'(MIN_HIGH_CYCLES);
  localparam logic [HCNT_W-1:0] H_MAX  = HCNT_W'(MAX_HIGH_CYCLES);
  localparam logic [HCNT_W-1:0] H_ONE  = HCNT_W'(1);
  localparam logic [LCNT_W-1:0] L_RST  = LCNT_W'(RESET_CYCLES);
  localparam logic [LCNT_W-1:0] L_ONE  = LCNT_W'(1);
  localparam logic [BCNT_W-1:0] B_LAST = BCNT_W'(PIXEL_W - 1);
  localparam logic [BCNT_W-1:0] B_ONE  = BCNT_W'(1);

  logic                din_lvl;
  logic                rise;
  logic                fall;
  rx_state_t           state;
  logic [HCNT_W-1:0]   hcnt;
  logic [LCNT_W-1:0]   lcnt;
  logic [BCNT_W-1:0]   bitcnt;
  logic [PIXEL_W-1:0]  shreg;
  logic [15:0]         pcnt;
  logic                bit_val;
  logic [PIXEL_W-1:0]  shifted;

  function automatic logic [HCNT_W-1:0] hcnt_sat_inc(input logic [HCNT_W-1:0] v);
    return (v >= H_MAX) ? v : v + H_ONE;
  endfunction

  function automatic logic [LCNT_W-1:0] lcnt_sat_inc(input logic [LCNT_W-1:0] v);
    return (v >= L_RST) ? v : v + L_ONE;
  endfunction

  function automatic logic [15:0] pcnt_sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  ws2812b_din_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_din_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (DIN),
    .din_lvl(din_lvl),
    .rise   (rise),
    .fall   (fall)
  );

  // Decoded bit of the pulse that is ending and the shifter's next value
  always_comb begin
    bit_val = (hcnt >= H_THR);
    shifted = {shreg[PIXEL_W-2:0], bit_val};
  end

  // Receiver FSM: pulse measurement, bit shifting, pixel and frame strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_SYNC;
      hcnt         <= '0;
      lcnt         <= '0;
      bitcnt       <= '0;
      shreg        <= '0;
      pcnt         <= '0;
      pixel_data   <= '0;
      pixel_valid  <= 1'b0;
      pixel_index  <= '0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      bit_error    <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      bit_error   <= 1'b0;
      case (state)
        // Wait for a full low gap before trusting any edge
        ST_SYNC: begin
          if (din_lvl) begin
            lcnt <= '0;
          end else if (lcnt >= L_RST) begin
            lcnt  <= '0;
            state <= ST_IDLE;
          end else begin
            lcnt <= lcnt_sat_inc(lcnt);
          end
        end
        ST_IDLE: begin
          if (rise) begin
            hcnt  <= H_ONE;
            state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            if (hcnt < H_MIN || hcnt >= H_MAX) begin
              bit_error <= 1'b1;
              bitcnt    <= '0;
              pcnt      <= '0;
              lcnt      <= '0;
              state     <= ST_SYNC;
            end else begin
              shreg <= shifted;
              if (bitcnt == B_LAST) begin
                pixel_data  <= shifted;
                pixel_valid <= 1'b1;
                pixel_index <= pcnt;
                pcnt        <= pcnt_sat_inc(pcnt);
                bitcnt      <= '0;
              end else begin
                bitcnt <= bitcnt + B_ONE;
              end
              lcnt  <= L_ONE;
              state <= ST_LOW;
            end
          end else if (hcnt >= H_MAX) begin
            // Stuck high: drop everything and resynchronize
            bit_error <= 1'b1;
            bitcnt    <= '0;
            pcnt      <= '0;
            lcnt      <= '0;
            state     <= ST_SYNC;
          end else begin
            hcnt <= hcnt_sat_inc(hcnt);
          end
        end
        ST_LOW: begin
          if (rise) begin
            hcnt  <= H_ONE;
            state <= ST_HIGH;
          end else if (lcnt >= L_RST) begin
            // Frame end; a partial pixel is reported and dropped
            frame_done   <= 1'b1;
            frame_pixels <= pcnt;
            bit_error    <= (bitcnt != '0);
            pcnt         <= '0;
            bitcnt       <= '0;
            lcnt         <= '0;
            state        <= ST_IDLE;
          end else begin
            lcnt <= lcnt_sat_inc(lcnt);
          end
        end
        default: state <= ST_SYNC;
      endcase
    end
  end

`ifdef WS2812B_RX_FORWARD_EN
  logic fwd;

  // Forwarding window: opens after this node's own pixel, closes at frame end or error
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd <= 1'b0;
    end else if (frame_done || bit_error) begin
      fwd <= 1'b0;
    end else if (pixel_valid) begin
      fwd <= 1'b1;
    end
  end

  assign DOUT = fwd & din_lvl;
`else
  assign DOUT = 1'b0;
`endif

endmodule

// File: tb/tb_ws2812b_rx.sv
// Testbench for ws2812b_rx: table-driven threshold vectors, hand-written
// sequences for frame/error/reset corners, and random pulse widths checked
// against a pulse-level reference model.
module tb_ws2812b_rx;
  import ws2812b_pkg::*;

  localparam int RST_C = RESET_CYCLES_DEFAULT;
  localparam int GAP   = RST_C + 20;
  localparam int THR   = 60;
  localparam int HMIN  = 15;
  localparam int HMAX  = 120;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        din = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [15:0] pixel_index;
  logic        frame_done;
  logic [15:0] frame_pixels;
  logic        bit_error;
  logic        dout;

  always #5 clk = ~clk;

  ws2812b_rx dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .DIN         (din),
    .pixel_data  (pixel_data),
    .pixel_valid (pixel_valid),
    .pixel_index (pixel_index),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .bit_error   (bit_error),
    .DOUT        (dout)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] data;
    logic [15:0] idx;
    int unsigned t;
  } pix_ev_t;

  typedef struct {
    logic [15:0] cnt;
    logic        err;
    int unsigned t;
  } frm_ev_t;

  pix_ev_t got_pix[$];
  frm_ev_t got_frm[$];
  int      got_err = 0;
  int      overlap = 0;

  // Observed strobes, sampled on the falling edge
  always @(negedge clk) begin
    if (reset_n) begin
      if (pixel_valid) got_pix.push_back('{pixel_data, pixel_index, cyc});
      if (frame_done) got_frm.push_back('{frame_pixels, bit_error, cyc});
      else if (bit_error) got_err++;
      if (pixel_valid && frame_done) overlap++;
    end
  end

`ifdef WS2812B_RX_FORWARD_EN
  logic [23:0] pd2;
  logic        pv2;
  logic [15:0] pi2;
  logic        fd2;
  logic [15:0] fp2;
  logic        be2;
  logic        dout2;
  pix_ev_t     g2_pix[$];
  frm_ev_t     g2_frm[$];

  ws2812b_rx rx2 (
    .clk         (clk),
    .reset_n     (reset_n),
    .DIN         (dout),
    .pixel_data  (pd2),
    .pixel_valid (pv2),
    .pixel_index (pi2),
    .frame_done  (fd2),
    .frame_pixels(fp2),
    .bit_error   (be2),
    .DOUT        (dout2)
  );

  always @(negedge clk) begin
    if (reset_n) begin
      if (pv2) g2_pix.push_back('{pd2, pi2, cyc});
      if (fd2) g2_frm.push_back('{fp2, be2, cyc});
    end
  end
`endif

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- reference model (pulse level) ----------------
  bit          m_synced = 1'b0;
  bit          m_active = 1'b0;
  int          m_bits = 0;
  int          m_npix = 0;
  logic [23:0] m_acc = '0;
  pix_ev_t     exp_pix[$];
  frm_ev_t     exp_frm[$];
  int          exp_err = 0;

  task automatic m_reset();
    m_synced = 1'b0;
    m_active = 1'b0;
    m_bits   = 0;
    m_npix   = 0;
  endtask

  task automatic m_pulse(input int hi);
    logic [15:0] idx;
    if (!m_synced) return;
    if (hi < HMIN || hi >= HMAX) begin
      exp_err++;
      m_reset();
    end else begin
      m_active = 1'b1;
      m_acc    = {m_acc[22:0], (hi >= THR) ? 1'b1 : 1'b0};
      m_bits++;
      if (m_bits == 24) begin
        idx = (m_npix > 65535) ? 16'hFFFF : 16'(m_npix);
        exp_pix.push_back('{m_acc, idx, 0});
        m_npix++;
        m_bits = 0;
      end
    end
  endtask

  task automatic m_gap(input int n);
    logic [15:0] cnt;
    if (n > RST_C) begin
      if (m_synced && m_active) begin
        cnt = (m_npix > 65535) ? 16'hFFFF : 16'(m_npix);
        exp_frm.push_back('{cnt, (m_bits != 0), 0});
      end
      m_synced = 1'b1;
      m_active = 1'b0;
      m_bits   = 0;
      m_npix   = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " pixel count"}, got_pix.size(), exp_pix.size());
    for (int i = 0; i < got_pix.size() && i < exp_pix.size(); i++) begin
      chk({tag, " pixel data"}, got_pix[i].data, exp_pix[i].data);
      chk({tag, " pixel index"}, got_pix[i].idx, exp_pix[i].idx);
    end
    chk({tag, " frame count"}, got_frm.size(), exp_frm.size());
    for (int i = 0; i < got_frm.size() && i < exp_frm.size(); i++) begin
      chk({tag, " frame pixels"}, got_frm[i].cnt, exp_frm[i].cnt);
      chk({tag, " frame partial err"}, got_frm[i].err, exp_frm[i].err);
    end
    chk({tag, " bit errors"}, got_err, exp_err);
    chk({tag, " valid/done overlap"}, overlap, 0);
    got_pix.delete();
    got_frm.delete();
    exp_pix.delete();
    exp_frm.delete();
    got_err = 0;
    exp_err = 0;
  endtask

  // ---------------- pin drivers ----------------
  int unsigned last_fall = 0;

  task automatic hold(input logic lv, input int n);
    din = lv;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    m_pulse(hi);
    hold(1'b1, hi);
    last_fall = cyc;
    hold(1'b0, lo);
  endtask

  task automatic gap(input int n);
    m_gap(n);
    hold(1'b0, n);
  endtask

  task automatic send_pkg(input logic [23:0] d, input int nbits);
    for (int b = 0; b < nbits; b++) begin
      if (d[23-b]) pulse(T1H, T1L);
      else         pulse(T0H, T0L);
    end
  endtask

  task automatic send_w(input logic [23:0] d, input int hi0, input int hi1,
                        input int lo, input int nbits);
    for (int b = 0; b < nbits; b++) pulse(d[23-b] ? hi1 : hi0, lo);
  endtask

  typedef struct {
    int          hi0;
    int          hi1;
    logic [23:0] data;
    int          nbits;
    bit          exp_err;
    logic [23:0] exp_data;
  } vec_t;

  vec_t        vecs[4];
  int unsigned t_fall0;
  int unsigned t_fall2;

  initial begin
    vecs[0] = '{59, 60,  24'hC3A55A, 24, 1'b0, 24'hC3A55A};
    vecs[1] = '{15, 119, 24'h5A0FF0, 24, 1'b0, 24'h5A0FF0};
    vecs[2] = '{14, 80,  24'h000000, 1,  1'b1, 24'h000000};
    vecs[3] = '{40, 120, 24'h800000, 1,  1'b1, 24'h000000};

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset pixel_data", pixel_data, 0);
    chk("reset pixel_valid", pixel_valid, 0);
    chk("reset pixel_index", pixel_index, 0);
    chk("reset frame_done", frame_done, 0);
    chk("reset frame_pixels", frame_pixels, 0);
    chk("reset bit_error", bit_error, 0);
    chk("reset DOUT", dout, 0);
    reset_n = 1'b1;
    m_reset();

    // Nominal frame with package timings
    gap(6000);
    send_pkg(24'hABCDEF, 24);
    t_fall0 = last_fall;
    send_pkg(24'h123456, 24);
    send_pkg(24'h2468AC, 24);
    t_fall2 = last_fall;
    gap(6000);
    chk("nominal pixel count", got_pix.size(), 3);
    if (got_pix.size() == 3) begin
      chk("nominal px0 data", got_pix[0].data, 24'hABCDEF);
      chk("nominal px1 data", got_pix[1].data, 24'h123456);
      chk("nominal px2 data", got_pix[2].data, 24'h2468AC);
      chk("nominal px0 index", got_pix[0].idx, 0);
      chk("nominal px1 index", got_pix[1].idx, 1);
      chk("nominal px2 index", got_pix[2].idx, 2);
      chk("nominal pixel latency", got_pix[0].t - t_fall0, 4);
    end
    chk("nominal frame count", got_frm.size(), 1);
    if (got_frm.size() == 1) begin
      chk("nominal frame_pixels", got_frm[0].cnt, 3);
      chk("nominal frame err", got_frm[0].err, 0);
      chk("nominal frame latency", got_frm[0].t - t_fall2, RST_C + 4);
    end
    chk("nominal bit_error", got_err, 0);
`ifdef WS2812B_RX_FORWARD_EN
    chk("fwd pixel count", g2_pix.size(), 2);
    if (g2_pix.size() == 2) begin
      chk("fwd px0 data", g2_pix[0].data, 24'h123456);
      chk("fwd px1 data", g2_pix[1].data, 24'h2468AC);
      chk("fwd px0 index", g2_pix[0].idx, 0);
      chk("fwd px1 index", g2_pix[1].idx, 1);
    end
    chk("fwd frame count", g2_frm.size(), 1);
    if (g2_frm.size() == 1) chk("fwd frame_pixels", g2_frm[0].cnt, 2);
    g2_pix.delete();
    g2_frm.delete();
`endif
    check_model("nominal");

    // Reset mid-pixel, then bits before a full gap must be ignored
    send_pkg(24'hFF0000, 8);
    reset_n = 1'b0;
    #2;
    chk("midreset pixel_data", pixel_data, 0);
    chk("midreset pixel_index", pixel_index, 0);
    chk("midreset frame_pixels", frame_pixels, 0);
    chk("midreset strobes", {29'd0, pixel_valid, frame_done, bit_error}, 0);
    chk("midreset DOUT", dout, 0);
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_pkg(24'h55AA55, 24);
    gap(GAP);
    chk("postreset no pixel", got_pix.size(), 0);
    check_model("postreset");

    // Threshold boundary vectors
    for (int v = 0; v < 4; v++) begin
      send_w(vecs[v].data, vecs[v].hi0, vecs[v].hi1, 20, vecs[v].nbits);
      gap(GAP);
      if (vecs[v].exp_err) begin
        chk($sformatf("vec%0d bit_error", v), got_err, 1);
        chk($sformatf("vec%0d no pixel", v), got_pix.size(), 0);
        chk($sformatf("vec%0d no frame", v), got_frm.size(), 0);
      end else begin
        chk($sformatf("vec%0d pixel count", v), got_pix.size(), 1);
        if (got_pix.size() == 1)
          chk($sformatf("vec%0d pixel_data", v), got_pix[0].data, vecs[v].exp_data);
        chk($sformatf("vec%0d frame count", v), got_frm.size(), 1);
        if (got_frm.size() == 1)
          chk($sformatf("vec%0d frame_pixels", v), got_frm[0].cnt, 1);
      end
      check_model($sformatf("vec%0d", v));
    end

    // Glitch mid-pixel: error, following bits ignored until a full gap
    send_pkg(24'hC30000, 8);
    pulse(10, T0L);
    send_pkg(24'hFF00FF, 8);
    gap(GAP);
    chk("glitch bit_error", got_err, 1);
    chk("glitch no pixel", got_pix.size(), 0);
    chk("glitch no frame", got_frm.size(), 0);
    check_model("glitch");

    // Random pulse widths after resync: decoding resumes
    for (int p = 0; p < 48; p++) pulse($urandom_range(119, 15), $urandom_range(60, 20));
    gap(GAP);
    chk("random pixel count", got_pix.size(), 2);
    check_model("random");

    // Partial pixel then gap: frame_done and bit_error together, zero pixels
    send_pkg(24'hF0F000, 12);
    gap(GAP);
    chk("partial frame count", got_frm.size(), 1);
    if (got_frm.size() == 1) begin
      chk("partial frame_pixels", got_frm[0].cnt, 0);
      chk("partial same-cycle err", got_frm[0].err, 1);
    end
    check_model("partial");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule
